// File: rtl/mem_bus_arbiter.sv
// Three-master arbiter for a single stb/ack memory bus, with fixed-priority or
// round-robin selection and a watchdog that aborts a hung transfer with an error pulse.
module mem_bus_arbiter #(
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [95:0] m_adr_i,
    input  logic [95:0] m_dat_i,
    input  logic [11:0] m_sel_i,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    output logic [31:0] m_dat_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [2:0]  grant_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic [1:0]     rr_q, rr_d;
    logic [TW-1:0]  wd_q, wd_d;

    logic [2:0]     winner;
    logic [1:0]     g_idx, g_next;
    logic           g_stb, done, timeout;

    // Rotate requests so the start position lands on bit 0, take the lowest
    // set bit, then rotate the one-hot result back.
    function automatic logic [2:0] first_from(input logic [2:0] req, input logic [1:0] start);
        logic [2:0] rot, p, res;
        case (start)
            2'd1:    rot = {req[0], req[2:1]};
            2'd2:    rot = {req[1:0], req[2]};
            default: rot = req;
        endcase
        if (rot[0])      p = 3'b001;
        else if (rot[1]) p = 3'b010;
        else if (rot[2]) p = 3'b100;
        else             p = 3'b000;
        case (start)
            2'd1:    res = {p[1:0], p[2]};
            2'd2:    res = {p[0], p[2:1]};
            default: res = p;
        endcase
        return res;
    endfunction

    always_comb begin
        winner = first_from(m_stb_i, (RR_EN != 0) ? rr_q : 2'd0);
        if (grant_q[1])      g_idx = 2'd1;
        else if (grant_q[2]) g_idx = 2'd2;
        else                 g_idx = 2'd0;
        g_next = (g_idx == 2'd2) ? 2'd0 : g_idx + 2'd1;
    end

    // Slave-side mux follows the granted master's live inputs; a zero grant
    // leaves the bus at all-zero.
    always_comb begin
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int k = 0; k < 3; k++) begin
            if (grant_q[k]) begin
                s_we_o  = m_we_i[k];
                s_adr_o = m_adr_i[32*k +: 32];
                s_dat_o = m_dat_i[32*k +: 32];
                s_sel_o = m_sel_i[4*k +: 4];
            end
        end
    end

    always_comb begin
        g_stb   = |(m_stb_i & grant_q);
        s_stb_o = (state_q == BUSY) && g_stb;
        done    = s_stb_o && s_ack_i;
        timeout = s_stb_o && !s_ack_i && (wd_q == TW'(TIMEOUT - 1));
        m_ack_o = done    ? grant_q : 3'b000;
        m_err_o = timeout ? grant_q : 3'b000;
        m_dat_o = done    ? s_dat_i : 32'h0;
        grant_o = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (|m_stb_i) begin
                    state_d = BUSY;
                    grant_d = winner;
                    wd_d    = '0;
                end
            end
            BUSY: begin
                if (!g_stb) begin
                    // master withdrew: no response, pointer stays put
                    state_d = IDLE;
                    grant_d = '0;
                end else if (s_ack_i || timeout) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = g_next;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end

endmodule
